// File: rtl/sw_conditioner.sv
// Slide-switch conditioner: per-bit synchroniser, consecutive-sample debounce, edge pulses, settle FSM.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges from input change to o_sw; no backpressure, outputs update every cycle.
module sw_conditioner #(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_sw,
    output logic [WIDTH-1:0] o_sw,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic             o_changed,
    output logic             o_ready
);
    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SETTLE   = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int SETTLE_W = $clog2(SETTLE + 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic                 settle_done;
    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     ss;
    logic [CNT_W-1:0]     cnt [WIDTH];
    logic [WIDTH-1:0]     accept;

    assign ss          = sync_q[SYNC_STAGES-1];
    assign settle_done = (settle_cnt == SETTLE_W'(SETTLE - 1));
    assign o_ready     = (state == ST_RUN);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= i_sw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_INIT;
            settle_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT && !settle_done) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (settle_done) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    // A bit is accepted on the edge that would otherwise take its count to DEBOUNCE_CYCLES.
    always_comb begin
        accept = '0;
        for (int b = 0; b < WIDTH; b++) begin
            accept[b] = (state == ST_RUN) && (ss[b] != o_sw[b]) &&
                        (cnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sw      <= '0;
            o_rise    <= '0;
            o_fall    <= '0;
            o_changed <= 1'b0;
            for (int b = 0; b < WIDTH; b++) begin
                cnt[b] <= '0;
            end
        end else if (state == ST_INIT) begin
            o_sw      <= ss;
            o_rise    <= '0;
            o_fall    <= '0;
            o_changed <= 1'b0;
            for (int b = 0; b < WIDTH; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            o_sw      <= o_sw ^ accept;
            o_rise    <= accept & ss;
            o_fall    <= accept & ~ss;
            o_changed <= |accept;
            for (int b = 0; b < WIDTH; b++) begin
                if (ss[b] == o_sw[b] || accept[b]) begin
                    cnt[b] <= '0;
                end else begin
                    cnt[b] <= cnt[b] + 1'b1;
                end
            end
        end
    end
endmodule
